// File: rtl/cdc_fifo_gen.sv
// rtl/cdc_fifo_gen.sv - parametrised dual-clock show-ahead FIFO with levels and sticky error flags
module cdc_fifo_gen #(
    parameter int DATA_W      = 43,
    parameter int ADDR_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LVL   = 3,
    parameter int AEMPTY_LVL  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              wr_overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              rd_underflow
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AFULL_L   = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] AEMPTY_L  = (ADDR_W+1)'(AEMPTY_LVL);
    // Inverting the top two gray bits turns "same index, other lap" into an equality test.
    localparam logic [ADDR_W:0] FULL_MASK = (ADDR_W+1)'(3) << (ADDR_W - 1);

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] wgray;
    logic [ADDR_W:0] wptr_nxt;
    logic [ADDR_W:0] rq_sync [SYNC_STAGES];
    logic [ADDR_W:0] rq_bin;
    logic            push;

    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] rgray;
    logic [ADDR_W:0] rptr_nxt;
    logic [ADDR_W:0] wq_sync [SYNC_STAGES];
    logic [ADDR_W:0] wq_bin;
    logic            pop;

    // ---------------- write domain ----------------
    assign push     = wr_en && !full;
    assign wptr_nxt = wptr + PTR_ONE;

    // Write pointer, its registered gray copy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            wgray       <= '0;
            wr_overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr  <= wptr_nxt;
                wgray <= bin2gray(wptr_nxt);
            end
            if (wr_en && full) begin
                wr_overflow <= 1'b1;
            end
        end
    end

    // Bring the read-side gray pointer into the write domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq_sync[i] <= '0;
            end
        end else begin
            rq_sync[0] <= rgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq_sync[i] <= rq_sync[i-1];
            end
        end
    end

    // Storage array; left unreset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rq_bin      = gray2bin(rq_sync[SYNC_STAGES-1]);
    assign full        = (wgray == (rq_sync[SYNC_STAGES-1] ^ FULL_MASK));
    assign wr_level    = wptr - rq_bin;
    assign almost_full = (wr_level >= AFULL_L);

    // ---------------- read domain ----------------
    assign pop      = rd_en && !empty;
    assign rptr_nxt = rptr + PTR_ONE;

    // Read pointer, its registered gray copy and the sticky underflow flag.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rptr         <= '0;
            rgray        <= '0;
            rd_underflow <= 1'b0;
        end else begin
            if (pop) begin
                rptr  <= rptr_nxt;
                rgray <= bin2gray(rptr_nxt);
            end
            if (rd_en && empty) begin
                rd_underflow <= 1'b1;
            end
        end
    end

    // Bring the write-side gray pointer into the read domain.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wq_sync[i] <= '0;
            end
        end else begin
            wq_sync[0] <= wgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wq_sync[i] <= wq_sync[i-1];
            end
        end
    end

    assign wq_bin       = gray2bin(wq_sync[SYNC_STAGES-1]);
    assign empty        = (rgray == wq_sync[SYNC_STAGES-1]);
    assign rd_level     = wq_bin - rptr;
    assign almost_empty = (rd_level <= AEMPTY_L);
    // Show-ahead head word; when empty it simply shows whatever the slot last held.
    assign rd_data      = mem[rptr[ADDR_W-1:0]];

endmodule
